// File: rtl/rom_prefetch_pkg.sv
// rom_prefetch_pkg: shared defaults and sizing helper for the ROM prefetcher
package rom_prefetch_pkg;

    localparam int unsigned def_mem_size    = 8;
    localparam int unsigned def_data_width  = 16;
    localparam int unsigned def_fifo_depth  = 4;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rom_prefetch_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count and flush (flush beats push)
module sync_fifo
    import rom_prefetch_pkg::*;
#(
    parameter int unsigned width = 24,
    parameter int unsigned depth = 4,
    localparam int unsigned pw = $clog2(depth),
    localparam int unsigned cw = cnt_width(depth)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [cw-1:0]    count
);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    rd_q;
    logic [pw-1:0]    wr_q;
    logic [cw-1:0]    cnt_q;
    logic             do_pop;

    assign empty  = cnt_q == '0;
    assign full   = cnt_q == cw'(depth);
    assign head   = mem[rd_q];
    assign count  = cnt_q;
    assign do_pop = pop & ~empty;

    // pointers and occupancy; pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push ? wr_q + pw'(1) : wr_q;
            rd_q  <= do_pop ? rd_q + pw'(1) : rd_q;
            cnt_q <= cnt_q + cw'(push) - cw'(do_pop);
        end
    end

    // storage array, written only when the push survives a flush
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/rom_prefetch.sv
// rom_prefetch: sequential ROM fetcher that hides the 1-cycle read latency behind a small buffer
module rom_prefetch
    import rom_prefetch_pkg::*;
#(
    parameter int unsigned          memSize_p   = def_mem_size,
    parameter int unsigned          dataWidth_p = def_data_width,
    parameter int unsigned          fifoDepth_p = def_fifo_depth,
    parameter logic [memSize_p-1:0] resetAddr_p = '0
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    output logic [memSize_p-1:0]   romAddr_o,
    input  logic [dataWidth_p-1:0] romData_i,
    input  logic                   redirect_i,
    input  logic [memSize_p-1:0]   redirectAddr_i,
    output logic [dataWidth_p-1:0] data_o,
    output logic [memSize_p-1:0]   dataAddr_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    localparam int unsigned cw = cnt_width(fifoDepth_p);

    logic [memSize_p-1:0]             pc_q;
    logic [memSize_p-1:0]             tag_q;
    logic                             inflight_q;
    logic [cw-1:0]                    count;
    logic [cw:0]                      used;
    logic                             full;
    logic                             empty;
    logic                             issue;
    logic                             push;
    logic                             pop;
    logic [dataWidth_p+memSize_p-1:0] head;

    // buffered plus in-flight words must leave room; same-cycle pops do not free credit
    assign used      = {1'b0, count} + {{cw{1'b0}}, inflight_q};
    assign issue     = redirect_i | (used < (cw+1)'(fifoDepth_p));
    assign romAddr_o = redirect_i ? redirectAddr_i : pc_q;
    assign push      = inflight_q & ~redirect_i;
    assign valid_o   = ~empty;
    assign pop       = valid_o & ready_i;
    assign {data_o, dataAddr_o} = head;

    // fetch pointer, and the address tag of the read whose data returns next cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q       <= resetAddr_p;
            tag_q      <= resetAddr_p;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            tag_q      <= issue ? romAddr_o : tag_q;
            pc_q       <= issue ? romAddr_o + memSize_p'(1) : pc_q;
        end
    end

    sync_fifo #(
        .width(dataWidth_p + memSize_p),
        .depth(fifoDepth_p)
    ) u_fifo (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata ({romData_i, tag_q}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && full));

endmodule

// File: tb/tb_rom_prefetch.sv
// tb_rom_prefetch: directed checks of streaming, backpressure, redirect, wrap and reset
module tb_rom_prefetch;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        ready_i = 1'b1;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [15:0] data;
    logic [7:0]  data_addr;
    logic        valid;
    logic [7:0]  exp_addr = 8'h00;
    logic [7:0]  tmp;
    int          total = 0;
    int          bad = 0;

    rom_prefetch dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .romAddr_o     (rom_addr),
        .romData_i     (rom_data),
        .redirect_i    (redirect_i),
        .redirectAddr_i(redirect_addr),
        .data_o        (data),
        .dataAddr_o    (data_addr),
        .valid_o       (valid),
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // synchronous ROM holding addr ^ A5A5 with a one-cycle registered read
    always @(posedge clk_i) rom_data <= {8'h00, rom_addr} ^ 16'hA5A5;

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++;
        if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_romaddr: got %h want 00", rom_addr); end
        rstn_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL first_valid_early: got %b want 0", valid); end
        @(negedge clk_i);
        total++;
        if ({valid, data_addr, data} !== {1'b1, 8'h00, 16'hA5A5})
            begin bad++; $display("FAIL first_word: got v=%b a=%h d=%h want v=1 a=00 d=a5a5", valid, data_addr, data); end
        exp_addr = 8'h00;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            exp_addr++;
            total++;
            if ({valid, data_addr, data} !== {1'b1, exp_addr, {8'h00, exp_addr} ^ 16'hA5A5})
                begin bad++; $display("FAIL stream: got v=%b a=%h d=%h want a=%h", valid, data_addr, data, exp_addr); end
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        repeat (10) @(negedge clk_i);
        total++;
        if ({valid, data_addr} !== {1'b1, exp_addr})
            begin bad++; $display("FAIL bp_hold: got v=%b a=%h want v=1 a=%h", valid, data_addr, exp_addr); end
        tmp = exp_addr + 8'd4;
        total++;
        if (rom_addr !== tmp) begin bad++; $display("FAIL bp_stop: got %h want %h", rom_addr, tmp); end
        @(negedge clk_i);
        total++;
        if (rom_addr !== tmp) begin bad++; $display("FAIL bp_stall: got %h want %h", rom_addr, tmp); end
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            exp_addr++;
            total++;
            if ({valid, data_addr, data} !== {1'b1, exp_addr, {8'h00, exp_addr} ^ 16'hA5A5})
                begin bad++; $display("FAIL bp_resume: got v=%b a=%h d=%h want a=%h", valid, data_addr, data, exp_addr); end
        end
    endtask

    task automatic test_redirect();
        ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        redirect_i = 1'b1;
        redirect_addr = 8'h40;
        ready_i = 1'b1;
        #1;
        total++;
        if (rom_addr !== 8'h40) begin bad++; $display("FAIL redir_romaddr: got %h want 40", rom_addr); end
        @(negedge clk_i);
        redirect_i = 1'b0;
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", valid); end
        exp_addr = 8'h40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if ({valid, data_addr, data} !== {1'b1, exp_addr, {8'h00, exp_addr} ^ 16'hA5A5})
                begin bad++; $display("FAIL redir_stream: got v=%b a=%h d=%h want a=%h", valid, data_addr, data, exp_addr); end
            exp_addr++;
        end
    endtask

    task automatic test_back_to_back();
        redirect_i = 1'b1;
        redirect_addr = 8'h10;
        @(negedge clk_i);
        redirect_addr = 8'h80;
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL b2b_flush1: got %b want 0", valid); end
        @(negedge clk_i);
        redirect_i = 1'b0;
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL b2b_flush2: got %b want 0", valid); end
        exp_addr = 8'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if ({valid, data_addr} !== {1'b1, exp_addr})
                begin bad++; $display("FAIL b2b_stream: got v=%b a=%h want a=%h", valid, data_addr, exp_addr); end
            exp_addr++;
        end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1;
        redirect_addr = 8'hFE;
        @(negedge clk_i);
        redirect_i = 1'b0;
        exp_addr = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if ({valid, data_addr, data} !== {1'b1, exp_addr, {8'h00, exp_addr} ^ 16'hA5A5})
                begin bad++; $display("FAIL wrap: got v=%b a=%h d=%h want a=%h", valid, data_addr, data, exp_addr); end
            exp_addr++;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", valid); end
        total++;
        if (rom_addr !== 8'h00) begin bad++; $display("FAIL midreset_romaddr: got %h want 00", rom_addr); end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL midreset_early: got %b want 0", valid); end
        exp_addr = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            total++;
            if ({valid, data_addr, data} !== {1'b1, exp_addr, {8'h00, exp_addr} ^ 16'hA5A5})
                begin bad++; $display("FAIL midreset_stream: got v=%b a=%h d=%h want a=%h", valid, data_addr, data, exp_addr); end
            exp_addr++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
